scan_adder_misr: RTL and testbench

- Parametrised registered adder with a full-scan chain through every flop. Adds a MISR signature mode, a hold mode and a chain-length shift counter.
- Successor to the fixed 4-bit scan adder. Used as the DFT-ready arithmetic leaf in the adder test area.
- The scan controller uses chain_full to know when a complete load or unload has finished.

---
 rtl/dft_pkg.sv | 31 +++
 rtl/scan_adder_misr_if.sv | 32 +++
 rtl/scan_adder_misr_misr_step.sv | 14 +
 rtl/scan_adder_misr.sv | 91 +++++++++
 tb/tb_scan_adder_misr.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dft_pkg.sv
// Shared DFT definitions for the scan adder family.
//   mode_e          : per-edge operating mode after priority decode
//   decode_mode()   : scan_enable > hold > misr_en > functional
//   chain_len()     : scan chain length for a WIDTH-bit registered adder
//   DEFAULT_MISR_POLY : x^5+x^2+1 taps for the 5-bit signature at WIDTH=4
package dft_pkg;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    HOLD  = 2'd1,
    MISR  = 2'd2,
    FUNC  = 2'd3
  } mode_e;

  localparam logic [4:0] DEFAULT_MISR_POLY = 5'b00101;

  // a_q + b_q + sum_q (sum is one bit wider than the operands)
  function automatic int chain_len(input int width);
    return 3 * width + 1;
  endfunction

  function automatic mode_e decode_mode(input logic scan_enable,
                                        input logic hold,
                                        input logic misr_en);
    if (scan_enable) return SHIFT;
    if (hold)        return HOLD;
    if (misr_en)     return MISR;
    return FUNC;
  endfunction

endpackage

// File: rtl/scan_adder_misr_if.sv
// Control/data bundle for scan_adder_misr.
//   master : drives mode controls, scan_in and operands; samples results
//   slave  : the adder itself
// CW is derived from WIDTH and is not meant to be overridden.
interface scan_adder_misr_if
  import dft_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(chain_len(WIDTH) + 1);

  logic             scan_enable;
  logic             hold;
  logic             misr_en;
  logic             scan_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             scan_out;
  logic [CW-1:0]    shift_count;
  logic             chain_full;

  modport master (
    output scan_enable, hold, misr_en, scan_in, a, b,
    input  sum, scan_out, shift_count, chain_full
  );

  modport slave (
    input  scan_enable, hold, misr_en, scan_in, a, b,
    output sum, scan_out, shift_count, chain_full
  );
endinterface

// File: rtl/scan_adder_misr_misr_step.sv
// misr_step: combinational next-signature of a (WIDTH+1)-bit MISR.
//   sig  : current signature
//   data : parallel word folded into the signature
//   nxt  : shifted signature, reduced by POLY when the MSB falls out, xor data
module misr_step #(
  parameter int             WIDTH = 4,
  parameter logic [WIDTH:0] POLY  = 5'b00101
) (
  input  logic [WIDTH:0] sig,
  input  logic [WIDTH:0] data,
  output logic [WIDTH:0] nxt
);
  assign nxt = {sig[WIDTH-1:0], 1'b0} ^ (sig[WIDTH] ? POLY : '0) ^ data;
endmodule

// File: rtl/scan_adder_misr.sv
// scan_adder_misr: registered WIDTH-bit adder with a full scan chain,
// MISR signature compaction into the sum register, hold, and a shift counter
// that pulses chain_full after every L consecutive shift edges.
//   CK, rst_n : clock (rising edge), async active-low reset
//   bus       : slave side of scan_adder_misr_if (controls, operands, results)
// Chain order: scan_in -> a_q[0..W-1] -> b_q[0..W-1] -> sum_q[0..W] -> scan_out
module scan_adder_misr
  import dft_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH:0] MISR_POLY = DEFAULT_MISR_POLY
) (
  input  logic                     CK,
  input  logic                     rst_n,
  scan_adder_misr_if.slave         bus
);
  localparam int L  = chain_len(WIDTH);
  localparam int CW = $clog2(L + 1);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;

  logic [WIDTH:0]   add_res, misr_nxt;
  logic [L-1:0]     chain_q, chain_nxt;
  mode_e            mode;

  // Packing sum/b/a this way puts a_q[0] at bit 0, so a left shift walks the
  // chain in scan order and the MSB (sum_q[WIDTH]) is what leaves.
  assign chain_q   = {sum_q, b_q, a_q};
  assign chain_nxt = {chain_q[L-2:0], bus.scan_in};
  assign add_res   = {1'b0, a_q} + {1'b0, b_q};

  misr_step #(.WIDTH(WIDTH), .POLY(MISR_POLY)) u_misr (
    .sig  (sum_q),
    .data (add_res),
    .nxt  (misr_nxt)
  );

  always_comb begin
    mode   = decode_mode(bus.scan_enable, bus.hold, bus.misr_en);
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    cnt_d  = '0;     // any non-shift edge drops a partial count
    full_d = 1'b0;
    unique case (mode)
      SHIFT: begin
        {sum_d, b_d, a_d} = chain_nxt;
        // wrap on the L-th shift; the pulse lands in the following cycle
        if (cnt_q == CW'(L - 1)) full_d = 1'b1;
        else                     cnt_d  = cnt_q + CW'(1);
      end
      HOLD: begin
      end
      MISR: begin
        a_d   = bus.a;
        b_d   = bus.b;
        sum_d = misr_nxt;
      end
      FUNC: begin
        a_d   = bus.a;
        b_d   = bus.b;
        sum_d = add_res;
      end
    endcase
  end

  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign bus.sum         = sum_q;
  assign bus.scan_out    = sum_q[WIDTH];
  assign bus.shift_count = cnt_q;
  assign bus.chain_full  = full_q;

endmodule

// File: tb/tb_scan_adder_misr.sv
// Bench for scan_adder_misr at WIDTH=4 (L=13). A behavioural model of the
// architectural state predicts each edge; predictions are queued when the
// stimulus is driven and popped after the edge. Key points are also checked
// against fixed constants.
module tb_scan_adder_misr;
  localparam int W  = 4;
  localparam int L  = 13;
  localparam int CW = 4;

  logic CK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CK = ~CK;

  scan_adder_misr_if #(.WIDTH(W)) bus ();
  scan_adder_misr #(.WIDTH(W)) dut (.CK(CK), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W:0]    sum;
    logic          so;
    logic [CW-1:0] cnt;
    logic          full;
  } obs_t;

  obs_t sb[$];

  logic [W-1:0]  m_a, m_b;
  logic [W:0]    m_sum;
  logic [CW-1:0] m_cnt;
  logic          m_full;

  function automatic obs_t observe();
    return {bus.sum, bus.scan_out, bus.shift_count, bus.chain_full};
  endfunction

  task automatic model_clear();
    m_a = '0; m_b = '0; m_sum = '0; m_cnt = '0; m_full = 1'b0;
    sb.delete();
  endtask

  // Drive one edge worth of inputs, predict the post-edge outputs, wait.
  task automatic cyc(input logic se, input logic h, input logic me,
                     input logic si, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [L-1:0] ch;
    logic [W:0]   add;
    bus.scan_enable = se; bus.hold = h; bus.misr_en = me;
    bus.scan_in = si; bus.a = a; bus.b = b;
    add = {1'b0, m_a} + {1'b0, m_b};
    if (se) begin
      ch = {m_sum, m_b, m_a};
      ch = {ch[L-2:0], si};
      {m_sum, m_b, m_a} = ch;
      if (m_cnt == CW'(L - 1)) begin m_cnt = '0; m_full = 1'b1; end
      else begin m_cnt = m_cnt + 1'b1; m_full = 1'b0; end
    end else begin
      m_cnt = '0; m_full = 1'b0;
      if (!h) begin
        if (me) m_sum = ({m_sum[W-1:0], 1'b0} ^ (m_sum[W] ? 5'b00101 : 5'b00000)) ^ add;
        else    m_sum = add;
        m_a = a; m_b = b;
      end
    end
    sb.push_back({m_sum, m_sum[W], m_cnt, m_full});
    @(posedge CK); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    bus.scan_enable = 0; bus.hold = 0; bus.misr_en = 0; bus.scan_in = 0;
    bus.a = '0; bus.b = '0;
    @(posedge CK); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    rst_n = 1'b0;
    bus.scan_enable = 0; bus.hold = 0; bus.misr_en = 0;
    bus.scan_in = 1; bus.a = 4'd5; bus.b = 4'd9;
    repeat (2) @(posedge CK);
    #1;
    g = observe(); checks++;
    if (g !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got sum=%0d so=%b cnt=%0d full=%b want all zero",
               g.sum, g.so, g.cnt, g.full);
    end
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 1'(i % 2), 4'd0, 4'd0);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_preshift[%0d]: got sum=%0d so=%b cnt=%0d full=%b want sum=%0d so=%b cnt=%0d full=%b",
                 i, g.sum, g.so, g.cnt, g.full, e.sum, e.so, e.cnt, e.full);
      end
    end
    // async reset between edges, mid-shift
    rst_n = 1'b0;
    #1;
    g = observe(); checks++;
    if (g !== 11'd0) begin
      errors++;
      $display("FAIL reset_midshift: got sum=%0d so=%b cnt=%0d full=%b want all zero",
               g.sum, g.so, g.cnt, g.full);
    end
    rst_n = 1'b1;
    model_clear();
    cyc(1, 0, 0, 1'b0, 4'd0, 4'd0);
    g = observe(); checks++;
    if (g.cnt !== 4'd1) begin
      errors++;
      $display("FAIL reset_count_restart: got cnt=%0d want 1", g.cnt);
    end
    e = sb.pop_front(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_after_shift: got sum=%0d cnt=%0d want sum=%0d cnt=%0d", g.sum, g.cnt, e.sum, e.cnt);
    end
    do_reset();
  endtask

  task automatic test_functional();
    obs_t e, g;
    logic [W-1:0] av[6] = '{4'd7, 4'd7, 4'd15, 4'd15, 4'd3, 4'd3};
    logic [W-1:0] bv[6] = '{4'd8, 4'd8, 4'd15, 4'd15, 4'd5, 4'd5};
    logic         hv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W:0]   want[6] = '{5'd0, 5'd15, 5'd15, 5'd30, 5'd30, 5'd30};
    for (int i = 0; i < 6; i++) begin
      cyc(0, hv[i], 0, 0, av[i], bv[i]);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL func_model[%0d]: got sum=%0d cnt=%0d full=%b want sum=%0d cnt=%0d full=%b",
                 i, g.sum, g.cnt, g.full, e.sum, e.cnt, e.full);
      end
      checks++;
      if (bus.sum !== want[i]) begin
        errors++;
        $display("FAIL func_sum[%0d]: got %0d want %0d", i, bus.sum, want[i]);
      end
    end
  endtask

  task automatic test_full_shift();
    obs_t e, g;
    for (int i = 1; i <= L; i++) begin
      cyc(1, 0, 0, 1'b1, 4'd0, 4'd0);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL shift[%0d]: got sum=%0d so=%b cnt=%0d full=%b want sum=%0d so=%b cnt=%0d full=%b",
                 i, g.sum, g.so, g.cnt, g.full, e.sum, e.so, e.cnt, e.full);
      end
    end
    g = observe(); checks++;
    if (g !== {5'd31, 1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL shift_full: got sum=%0d so=%b cnt=%0d full=%b want sum=31 so=1 cnt=0 full=1",
               g.sum, g.so, g.cnt, g.full);
    end
    cyc(0, 0, 0, 0, 4'd0, 4'd0);
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || g.sum !== 5'd30 || g.full !== 1'b0) begin
      errors++;
      $display("FAIL shift_unload_add: got sum=%0d full=%b want sum=30 full=0", g.sum, g.full);
    end
  endtask

  task automatic test_interrupted();
    obs_t e, g;
    int pulses;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1'b0, 4'd0, 4'd0);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL intr_shift[%0d]: got cnt=%0d full=%b want cnt=%0d full=%b", i, g.cnt, g.full, e.cnt, e.full);
      end
    end
    checks++;
    if (bus.shift_count !== 4'd5) begin
      errors++;
      $display("FAIL intr_count5: got %0d want 5", bus.shift_count);
    end
    cyc(0, 0, 0, 0, 4'd0, 4'd0);
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || g.cnt !== 4'd0 || g.full !== 1'b0) begin
      errors++;
      $display("FAIL intr_stop: got cnt=%0d full=%b want cnt=0 full=0", g.cnt, g.full);
    end
    pulses = 0;
    for (int i = 1; i <= 2 * L; i++) begin
      cyc(1, 0, 0, 1'(i % 3 == 0), 4'd0, 4'd0);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL run26[%0d]: got sum=%0d cnt=%0d full=%b want sum=%0d cnt=%0d full=%b",
                 i, g.sum, g.cnt, g.full, e.sum, e.cnt, e.full);
      end
      if (g.full) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL run26_pulses: got %0d want 2", pulses);
    end
    cyc(0, 0, 0, 0, 4'd0, 4'd0);
    void'(sb.pop_front());
  endtask

  task automatic test_misr();
    obs_t e, g;
    logic [W:0] want[6] = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd26};
    do_reset();
    cyc(0, 0, 0, 0, 4'd1, 4'd0);
    e = sb.pop_front(); g = observe(); checks++;
    if (g !== e || g.sum !== 5'd0) begin
      errors++;
      $display("FAIL misr_seed: got sum=%0d want 0", g.sum);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 4'd1, 4'd0);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL misr_model[%0d]: got sum=%0d want %0d", i, g.sum, e.sum);
      end
      checks++;
      if (bus.sum !== want[i]) begin
        errors++;
        $display("FAIL misr_sum[%0d]: got %0d want %0d", i, bus.sum, want[i]);
      end
    end
  endtask

  task automatic test_priority();
    obs_t e, g;
    for (int i = 0; i < L + 2; i++) begin
      cyc(1, 1, 1, 1'(~i[0]), 4'd9, 4'd6);
      e = sb.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL prio[%0d]: got sum=%0d so=%b cnt=%0d full=%b want sum=%0d so=%b cnt=%0d full=%b",
                 i, g.sum, g.so, g.cnt, g.full, e.sum, e.so, e.cnt, e.full);
      end
      checks++;
      if (bus.shift_count !== CW'((i + 1) % L)) begin
        errors++;
        $display("FAIL prio_count[%0d]: got %0d want %0d", i, bus.shift_count, (i + 1) % L);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.scan_enable = 0; bus.hold = 0; bus.misr_en = 0; bus.scan_in = 0;
    bus.a = '0; bus.b = '0;
    model_clear();
    test_reset();
    test_functional();
    test_full_shift();
    test_interrupted();
    test_misr();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
